lc3_ctrl_exec: RTL and testbench
================================

// Module: lc3_ctrl_exec
// PURPOSE
// - LC-3 control and execute core: a microsequencer FSM plus the ALU and the address adder.
// - The FSM emits the 29-bit control word that drives bus gating, muxes, loads and memory strobes.
// - The ALU computes register results; the adder computes PC/base + offset addresses.
// - Sits between the datapath registers (IR, PC, MAR, MDR, NZP), the register file and RAM.
// PARAMETERS
// - W     16  datapath width
// - CW_W  29  control-word width
// PORTS
// - clock     in   1   sole clock, rising edge
// - reset_n   in   1   synchronous, active-low reset
// - start     in   1   leave IDLE and begin fetching
// - ir        in   16  current instruction register
// - n,z,p     in   1   condition codes
// - mem_r     in   1   memory ready; read/write completes this cycle
// - signal    out  29  registered control word
// - alu_a     in   16  SR1 operand
// - alu_b     in   16  SR2 or SEXT5 operand
// - alu_y     out  16  ALU result (op = signal[14:13])
// - addr1     in   16  ADDR1MUX output (PC or SR1)
// - addr2     in   16  ADDR2MUX output
// - addr_sum  out 16   addr1+addr2, mod 2^16
// BEHAVIOUR
// - Control-word fields:
//   - [2:0] DR, [5:3] SR2, [8:6] SR1.
//   - [10:9] bus gate: 00 PC, 01 MARMUX, 10 MDR, 11 ALU.
//   - [11] MEM.WE, [12] MEM.EN.
//   - [14:13] ALUK: 00 ADD, 01 AND, 10 NOT a, 11 PASS a.
//   - [16:15] ADDR2: 00 zero, 01 SEXT6, 10 SEXT9, 11 SEXT11.
//   - [18:17] PCMUX: 00 PC+1, 01 BUS, 10 adder.
//   - [19] SR2MUX: 1 = SEXT5. [20] ADDR1: 1 = SR1. [21] MARMUX: 1 = ZEXT(ir[7:0]).
//   - [22] MDRMUX: 1 = BUS.
//   - Loads: [23] REG, [24] IR, [25] PC, [26] CC, [27] MDR, [28] MAR.
// - ALU and adder are purely combinational; no latency, no saturation, wraps mod 2^16.
// - Moore FSM: signal is registered from the next state, so it is valid one cycle after entry.
// - Reset (reset_n=0 at a clock edge):
//   - state IDLE, signal = 0; this aborts any in-flight instruction, including a memory wait.
// - IDLE: stays until start=1, then goes to F1.
// - Fetch:
//   - F1: MAR<-PC, PC<-PC+1.
//   - F2: MEM.EN, MDR<-M; holds while mem_r=0.
//   - F3: IR<-MDR.
//   - DEC: 16-way branch on ir[15:12].
// - Register fields: DR=ir[11:9], SR1=ir[8:6], SR2=ir[2:0]. Store source is sent on the SR1 field as ir[11:9].
// - Execute states (each ends in F1):
//   - ADD/AND: DR<-ALU, LD.CC. SR2MUX=ir[5].
//   - NOT: DR<-~SR1, LD.CC.
//   - BR: if (ir[11]&n)|(ir[10]&z)|(ir[9]&p), PC<-PC+SEXT9; otherwise no-op.
//   - JMP: PC<-SR1.
//   - JSR/JSRR: R7<-PC, then PC<-PC+SEXT11 (ir[11]=1) or PC<-SR1.
//   - LD/LDR/LEA: MAR<-addr; then MDR<-M (wait on mem_r); then DR<-MDR, LD.CC. LEA loads DR<-addr directly, no CC.
//   - LDI/STI: one extra indirect read, MAR<-MDR.
//   - ST/STR: MAR<-addr, MDR<-PASS SR, MEM.EN+WE until mem_r.
// - Reserved opcodes 1000, 1101: treated as NOP, return to F1.
// - mem_r already 1 on entering a memory state: the access completes in that single cycle.
// - signal changes only on clock edges.
// CONFIGURATION
// - LC3_TRAP_EN defined: TRAP executes R7<-PC, MAR<-ZEXT(ir[7:0]), MDR<-M, PC<-MDR.
// - LC3_TRAP_EN undefined: TRAP enters HALT, signal=0 until reset.
// STRUCTURE
// - Package lc3_pkg: state enum, opcode localparams, control-bit index constants, ALUK/PCMUX/gate codes.
// - Sub-module lc3_alu (ALU + adder); FSM stays in the top module.
// TESTING
// - Reset, then start=1, mem_r=1 -> F1 word: bits 28, 25 and gate=00 set; F2 then F3 follow, one cycle each.
// - ir=0x1042, alu_a=5, alu_b=7 -> alu_y=12; word has REG, CC, gate=11, DR=0.
// - ALUK=01 a=0xF0F0 b=0x0FF0 -> 0x00F0; NOT 0x0000 -> 0xFFFF; addr 0xFFFF+1 -> 0x0000.
// - BR ir=0x0402, z=1 -> PCMUX=10, LD.PC; z=0 -> no LD.PC, next is F1.
// - LD with mem_r=0 for 3 cycles -> F2-type state holds 3 cycles, MEM.EN steady, then LD.MDR.
// - reset_n=0 mid-STI -> next cycle signal=0, state IDLE; TRAP behaviour checked with and without LC3_TRAP_EN.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 control/execute slice: FSM states,
// opcodes, control-word bit positions and field encodings.
package lc3_pkg;

    typedef enum logic [4:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC,
        S_ALU, S_NOT, S_BR, S_JMP, S_JSR1, S_JSR2, S_LEA,
        S_MARA, S_IND_RD, S_IND_MAR, S_RD, S_WB, S_ST_MDR, S_WR,
        S_TRAP1, S_TRAP2, S_TRAP3, S_TRAP4, S_HALT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam int CB_DR     = 0;
    localparam int CB_SR2    = 3;
    localparam int CB_SR1    = 6;
    localparam int CB_GATE   = 9;
    localparam int CB_WE     = 11;
    localparam int CB_EN     = 12;
    localparam int CB_ALUK   = 13;
    localparam int CB_ADDR2  = 15;
    localparam int CB_PCMUX  = 17;
    localparam int CB_SR2MUX = 19;
    localparam int CB_ADDR1  = 20;
    localparam int CB_MARMUX = 21;
    localparam int CB_MDRMUX = 22;
    localparam int CB_LDREG  = 23;
    localparam int CB_LDIR   = 24;
    localparam int CB_LDPC   = 25;
    localparam int CB_LDCC   = 26;
    localparam int CB_LDMDR  = 27;
    localparam int CB_LDMAR  = 28;

    localparam logic [1:0] GATE_PC     = 2'b00;
    localparam logic [1:0] GATE_MARMUX = 2'b01;
    localparam logic [1:0] GATE_MDR    = 2'b10;
    localparam logic [1:0] GATE_ALU    = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] A2_ZERO   = 2'b00;
    localparam logic [1:0] A2_SEXT6  = 2'b01;
    localparam logic [1:0] A2_SEXT9  = 2'b10;
    localparam logic [1:0] A2_SEXT11 = 2'b11;

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_BUS   = 2'b01;
    localparam logic [1:0] PC_ADDER = 2'b10;

    function automatic logic br_taken(input logic [15:0] ir, input logic n, z, p);
        return (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational LC-3 ALU (ADD/AND/NOT/PASS) and the PC/base + offset address adder.
module lc3_alu
    import lc3_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [1:0]   aluk,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    output logic [W-1:0] alu_y,
    input  logic [W-1:0] addr1,
    input  logic [W-1:0] addr2,
    output logic [W-1:0] addr_sum
);

    always_comb begin
        alu_y = alu_a;
        case (aluk)
            ALUK_ADD:  alu_y = alu_a + alu_b;
            ALUK_AND:  alu_y = alu_a & alu_b;
            ALUK_NOT:  alu_y = ~alu_a;
            ALUK_PASS: alu_y = alu_a;
            default:   alu_y = alu_a;
        endcase
    end

    assign addr_sum = addr1 + addr2;

endmodule

// File: rtl/lc3_ctrl_exec.sv
// LC-3 microsequencer with registered 29-bit control word, plus ALU/adder.
// Define LC3_TRAP_EN to execute TRAP; otherwise TRAP halts until reset.
module lc3_ctrl_exec
    import lc3_pkg::*;
#(
    parameter int W    = 16,
    parameter int CW_W = 29
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [W-1:0]    ir,
    input  logic            n,
    input  logic            z,
    input  logic            p,
    input  logic            mem_r,
    output logic [CW_W-1:0] signal,
    input  logic [W-1:0]    alu_a,
    input  logic [W-1:0]    alu_b,
    output logic [W-1:0]    alu_y,
    input  logic [W-1:0]    addr1,
    input  logic [W-1:0]    addr2,
    output logic [W-1:0]    addr_sum
);

    state_t          state, nxt;
    logic [CW_W-1:0] cw;
    logic [3:0]      opcode;

    assign opcode = ir[W-1:W-4];

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start) nxt = S_F1;
            S_F1:     nxt = S_F2;
            S_F2:     if (mem_r) nxt = S_F3;
            S_F3:     nxt = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_AND: nxt = S_ALU;
                    OP_NOT:         nxt = S_NOT;
                    OP_BR:          nxt = S_BR;
                    OP_JMP:         nxt = S_JMP;
                    OP_JSR:         nxt = S_JSR1;
                    OP_LEA:         nxt = S_LEA;
                    OP_LD, OP_LDR, OP_LDI,
                    OP_ST, OP_STR, OP_STI: nxt = S_MARA;
`ifdef LC3_TRAP_EN
                    OP_TRAP:        nxt = S_TRAP1;
`else
                    OP_TRAP:        nxt = S_HALT;
`endif
                    default:        nxt = S_F1;   // reserved opcodes act as NOP
                endcase
            end
            S_JSR1:   nxt = S_JSR2;
            S_MARA: begin
                case (opcode)
                    OP_LDI, OP_STI: nxt = S_IND_RD;
                    OP_ST, OP_STR:  nxt = S_ST_MDR;
                    default:        nxt = S_RD;
                endcase
            end
            S_IND_RD:  if (mem_r) nxt = S_IND_MAR;
            S_IND_MAR: nxt = (opcode == OP_STI) ? S_ST_MDR : S_RD;
            S_RD:      if (mem_r) nxt = S_WB;
            S_ST_MDR:  nxt = S_WR;
            S_WR:      if (mem_r) nxt = S_F1;
`ifdef LC3_TRAP_EN
            S_TRAP1:   nxt = S_TRAP2;
            S_TRAP2:   nxt = S_TRAP3;
            S_TRAP3:   if (mem_r) nxt = S_TRAP4;
`endif
            S_HALT:    nxt = S_HALT;
            default:   nxt = S_F1;
        endcase
    end

    // Control word of the state being entered; it is registered alongside the state.
    always_comb begin
        cw = '0;
        case (nxt)
            S_F1: begin
                cw[CB_GATE +: 2]  = GATE_PC;
                cw[CB_PCMUX +: 2] = PC_INC;
                cw[CB_LDMAR]      = 1'b1;
                cw[CB_LDPC]       = 1'b1;
            end
            S_F2, S_IND_RD, S_RD, S_TRAP3: begin
                cw[CB_EN]    = 1'b1;
                cw[CB_LDMDR] = 1'b1;
            end
            S_F3: begin
                cw[CB_GATE +: 2] = GATE_MDR;
                cw[CB_LDIR]      = 1'b1;
            end
            S_ALU: begin
                cw[CB_DR +: 3]   = ir[11:9];
                cw[CB_SR1 +: 3]  = ir[8:6];
                cw[CB_SR2 +: 3]  = ir[2:0];
                cw[CB_GATE +: 2] = GATE_ALU;
                cw[CB_ALUK +: 2] = (opcode == OP_AND) ? ALUK_AND : ALUK_ADD;
                cw[CB_SR2MUX]    = ir[5];
                cw[CB_LDREG]     = 1'b1;
                cw[CB_LDCC]      = 1'b1;
            end
            S_NOT: begin
                cw[CB_DR +: 3]   = ir[11:9];
                cw[CB_SR1 +: 3]  = ir[8:6];
                cw[CB_GATE +: 2] = GATE_ALU;
                cw[CB_ALUK +: 2] = ALUK_NOT;
                cw[CB_LDREG]     = 1'b1;
                cw[CB_LDCC]      = 1'b1;
            end
            S_BR: begin
                cw[CB_ADDR2 +: 2] = A2_SEXT9;
                cw[CB_PCMUX +: 2] = PC_ADDER;
                cw[CB_LDPC]       = br_taken(ir, n, z, p);
            end
            S_JMP: begin
                cw[CB_SR1 +: 3]   = ir[8:6];
                cw[CB_ADDR1]      = 1'b1;
                cw[CB_ADDR2 +: 2] = A2_ZERO;
                cw[CB_PCMUX +: 2] = PC_ADDER;
                cw[CB_LDPC]       = 1'b1;
            end
            S_JSR1, S_TRAP1: begin
                cw[CB_DR +: 3]   = 3'd7;
                cw[CB_GATE +: 2] = GATE_PC;
                cw[CB_LDREG]     = 1'b1;
            end
            S_JSR2: begin
                cw[CB_SR1 +: 3]   = ir[8:6];
                cw[CB_ADDR1]      = ~ir[11];
                cw[CB_ADDR2 +: 2] = ir[11] ? A2_SEXT11 : A2_ZERO;
                cw[CB_PCMUX +: 2] = PC_ADDER;
                cw[CB_LDPC]       = 1'b1;
            end
            S_LEA: begin
                cw[CB_DR +: 3]    = ir[11:9];
                cw[CB_GATE +: 2]  = GATE_MARMUX;
                cw[CB_ADDR2 +: 2] = A2_SEXT9;
                cw[CB_LDREG]      = 1'b1;
            end
            S_MARA: begin
                cw[CB_GATE +: 2] = GATE_MARMUX;
                cw[CB_LDMAR]     = 1'b1;
                if (opcode == OP_LDR || opcode == OP_STR) begin
                    cw[CB_SR1 +: 3]   = ir[8:6];
                    cw[CB_ADDR1]      = 1'b1;
                    cw[CB_ADDR2 +: 2] = A2_SEXT6;
                end else begin
                    cw[CB_ADDR2 +: 2] = A2_SEXT9;
                end
            end
            S_IND_MAR: begin
                cw[CB_GATE +: 2] = GATE_MDR;
                cw[CB_LDMAR]     = 1'b1;
            end
            S_WB: begin
                cw[CB_DR +: 3]   = ir[11:9];
                cw[CB_GATE +: 2] = GATE_MDR;
                cw[CB_LDREG]     = 1'b1;
                cw[CB_LDCC]      = 1'b1;
            end
            S_ST_MDR: begin
                // store source travels on the SR1 field so the ALU can pass it
                cw[CB_SR1 +: 3]  = ir[11:9];
                cw[CB_GATE +: 2] = GATE_ALU;
                cw[CB_ALUK +: 2] = ALUK_PASS;
                cw[CB_MDRMUX]    = 1'b1;
                cw[CB_LDMDR]     = 1'b1;
            end
            S_WR: begin
                cw[CB_EN] = 1'b1;
                cw[CB_WE] = 1'b1;
            end
            S_TRAP2: begin
                cw[CB_GATE +: 2] = GATE_MARMUX;
                cw[CB_MARMUX]    = 1'b1;
                cw[CB_LDMAR]     = 1'b1;
            end
            S_TRAP4: begin
                cw[CB_GATE +: 2]  = GATE_MDR;
                cw[CB_PCMUX +: 2] = PC_BUS;
                cw[CB_LDPC]       = 1'b1;
            end
            default: cw = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            signal <= '0;
        end else begin
            state  <= nxt;
            signal <= cw;
        end
    end

    lc3_alu #(.W(W)) u_alu (
        .aluk     (signal[CB_ALUK +: 2]),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .addr1    (addr1),
        .addr2    (addr2),
        .addr_sum (addr_sum)
    );

endmodule

// File: tb/tb_lc3_ctrl_exec.sv
// Scoreboard bench for lc3_ctrl_exec: directed instruction sequences push expected
// control words / ALU / adder results; a negedge monitor pops and compares.
module tb_lc3_ctrl_exec;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    logic        mem_r = 1'b1;
    logic [15:0] ir = '0, alu_a = '0, alu_b = '0, addr1 = '0, addr2 = '0;
    logic [28:0] signal;
    logic [15:0] alu_y, addr_sum;

    typedef struct {
        int          cyc;
        int          kind;
        logic [28:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    lc3_ctrl_exec dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .ir       (ir),
        .n        (n),
        .z        (z),
        .p        (p),
        .mem_r    (mem_r),
        .signal   (signal),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .addr1    (addr1),
        .addr2    (addr2),
        .addr_sum (addr_sum)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [28:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = signal;
                1:       act = {13'b0, alu_y};
                default: act = {13'b0, addr_sum};
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_sig(input string nm, input logic [28:0] v);
        sb.push_back('{cyc, 0, v, nm});
    endtask

    task automatic chk_alu(input string nm, input logic [15:0] v);
        sb.push_back('{cyc, 1, {13'b0, v}, nm});
    endtask

    task automatic chk_add(input string nm, input logic [15:0] v);
        sb.push_back('{cyc, 2, {13'b0, v}, nm});
    endtask

    // F1..DEC with memory ready; ir is presented while in F3
    task automatic fetch(input logic [15:0] i);
        mem_r = 1'b1;
        step(); chk_sig("f1", 29'h1200_0000);
        step(); chk_sig("f2", 29'h0800_1000);
        step(); chk_sig("f3", 29'h0100_0400);
        ir = i;
        step(); chk_sig("dec", 29'h0);
    endtask

    initial begin
        step(); step(); chk_sig("reset", 29'h0);
        reset_n = 1'b1;
        step(); chk_sig("idle_hold", 29'h0);
        start = 1'b1;

        fetch(16'h1042);
        start = 1'b0;
        alu_a = 16'd5; alu_b = 16'd7;
        step(); chk_sig("add_cw", 29'h0480_0650); chk_alu("add_y", 16'd12);

        fetch(16'h5000);
        alu_a = 16'hF0F0; alu_b = 16'h0FF0; addr1 = 16'h3000; addr2 = 16'h0025;
        step(); chk_sig("and_cw", 29'h0480_2600); chk_alu("and_y", 16'h00F0);
        chk_add("addr_plain", 16'h3025);

        fetch(16'h903F);
        alu_a = 16'h0000; addr1 = 16'hFFFF; addr2 = 16'h0001;
        step(); chk_sig("not_cw", 29'h0480_4600); chk_alu("not_y", 16'hFFFF);
        chk_add("addr_wrap", 16'h0000);

        fetch(16'h0402);
        z = 1'b1;
        step(); chk_sig("br_taken", 29'h0205_0000);

        fetch(16'h0402);
        z = 1'b0; n = 1'b1; p = 1'b1;
        step(); chk_sig("br_not_taken", 29'h0005_0000);
        n = 1'b0; p = 1'b0;

        fetch(16'h2205);
        step(); chk_sig("ld_mar", 29'h1001_0200);
        mem_r = 1'b0;
        step(); chk_sig("ld_wait1", 29'h0800_1000);
        step(); chk_sig("ld_wait2", 29'h0800_1000);
        step(); chk_sig("ld_wait3", 29'h0800_1000);
        mem_r = 1'b1;
        step(); chk_sig("ld_wb", 29'h0480_0401);

        fetch(16'h64C3);
        step(); chk_sig("ldr_mar", 29'h1010_82C0);
        step(); chk_sig("ldr_rd", 29'h0800_1000);
        step(); chk_sig("ldr_wb", 29'h0480_0402);

        fetch(16'h3A01);
        step(); chk_sig("st_mar", 29'h1001_0200);
        step(); chk_sig("st_mdr", 29'h0840_6740);
        mem_r = 1'b0;
        step(); chk_sig("st_wr1", 29'h0000_1800);
        step(); chk_sig("st_wr2", 29'h0000_1800);

        fetch(16'h4803);
        step(); chk_sig("jsr_r7", 29'h0080_0007);
        step(); chk_sig("jsr_pc", 29'h0205_8000);

        fetch(16'hB601);
        step(); chk_sig("sti_mar", 29'h1001_0200);
        step(); chk_sig("sti_ind", 29'h0800_1000);
        reset_n = 1'b0;
        step(); chk_sig("sti_reset", 29'h0);
        reset_n = 1'b1;
        step(); chk_sig("post_reset_idle1", 29'h0);
        step(); chk_sig("post_reset_idle2", 29'h0);
        start = 1'b1;

        fetch(16'hF025);
        start = 1'b0;
`ifdef LC3_TRAP_EN
        step(); chk_sig("trap_r7", 29'h0080_0007);
        step(); chk_sig("trap_mar", 29'h1020_0200);
        step(); chk_sig("trap_rd", 29'h0800_1000);
        step(); chk_sig("trap_pc", 29'h0202_0400);
        step(); chk_sig("trap_f1", 29'h1200_0000);
`else
        step(); chk_sig("halt1", 29'h0);
        start = 1'b1;
        step(); chk_sig("halt2", 29'h0);
        step(); chk_sig("halt3", 29'h0);
        start = 1'b0;
`endif

        step(); step();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
